// File: rtl/regwrite_trace.sv
// regwrite_trace: register-write trace FIFO capturing {pc, reg, value} records.
// Define TRACE_DEDUP_EN to suppress writes that do not change the register value.
module regwrite_trace #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int REG_AW = 3,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [REG_AW-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W-1:0]          pc,
    input  logic [NREGS-1:0]           watch_mask,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [2*DATA_W+REG_AW-1:0] out_data,
    output logic [CNT_W-1:0]           count,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = 2*DATA_W+REG_AW;

    logic [RW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr, rnext;
    logic [RW-1:0] rec;
    logic          dup, qual, pop, full, push, drop;

`ifdef TRACE_DEDUP_EN
    logic [DATA_W-1:0] shadow [NREGS];

    assign dup = shadow[wr_addr] == wr_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset || clear) begin
            for (int i = 0; i < NREGS; i++) shadow[i] <= '0;
        end else if (wr_en) begin
            shadow[wr_addr] <= wr_data;
        end
    end
`else
    assign dup = 1'b0;
`endif

    assign rec       = {pc, wr_addr, wr_data};
    assign qual      = wr_en && watch_mask[wr_addr] && !dup;
    assign out_valid = count != '0;
    assign pop       = out_valid && out_ready;
    assign full      = count == CNT_W'(DEPTH);
    assign push      = qual && (!full || pop);
    assign drop      = qual && full && !pop;
    assign rnext     = AW'(rptr + 1'b1);

    always_ff @(posedge clk) begin
        if (!clear && push) mem[wptr] <= rec;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || clear) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
            out_data <= '0;
        end else begin
            if (push) wptr <= AW'(wptr + 1'b1);
            if (pop) rptr <= rnext;
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (drop) overflow <= 1'b1;
            if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            // Registered show-ahead head: holds its last value once drained
            if ((!out_valid && push) || (pop && count == CNT_W'(1) && push)) out_data <= rec;
            else if (pop && count > CNT_W'(1)) out_data <= mem[rnext];
        end
    end
endmodule

// File: tb/tb_regwrite_trace.sv
// tb_regwrite_trace: directed self-checking bench for regwrite_trace (DEPTH=4).
module tb_regwrite_trace;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [15:0] pc = '0;
    logic [7:0]  watch_mask = 8'hFF;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [34:0] out_data;
    logic [2:0]  count;
    logic        overflow;
    logic [7:0]  drop_cnt;
    int          checks = 0;
    int          errors = 0;

    regwrite_trace #(.DATA_W(16), .NREGS(8), .REG_AW(3), .DEPTH(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .pc(pc), .watch_mask(watch_mask), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .count(count),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [34:0] r(input logic [15:0] p, input logic [2:0] a, input logic [15:0] d);
        return {p, a, d};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic we, input logic [2:0] a, input logic [15:0] d,
                        input logic [15:0] p, input logic rdy, input logic clr);
        @(negedge clk);
        wr_en = we; wr_addr = a; wr_data = d; pc = p; out_ready = rdy; clear = clr;
        @(posedge clk);
        #1;
        wr_en = 1'b0; out_ready = 1'b0; clear = 1'b0;
    endtask

    initial begin
        #12 reset = 1'b0;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);

        step(1, 3'd1, 16'h0005, 16'h3000, 0, 0);
        chk("w1_valid", 64'(out_valid), 64'd1);
        chk("w1_data", 64'(out_data), 64'(r(16'h3000, 3'd1, 16'h0005)));
        chk("w1_count", 64'(count), 64'd1);
        step(0, 3'd0, 16'h0, 16'h0, 1, 0);
        chk("pop1_valid", 64'(out_valid), 64'd0);
        chk("pop1_count", 64'(count), 64'd0);
        chk("pop1_hold", 64'(out_data), 64'(r(16'h3000, 3'd1, 16'h0005)));

        watch_mask = 8'h01;
        step(1, 3'd0, 16'h0011, 16'h3001, 0, 0);
        step(1, 3'd1, 16'h00BB, 16'h3002, 0, 0);
        step(1, 3'd0, 16'h0022, 16'h3003, 0, 0);
        chk("mask_count", 64'(count), 64'd2);
        chk("mask_head0", 64'(out_data), 64'(r(16'h3001, 3'd0, 16'h0011)));
        step(0, 3'd0, 16'h0, 16'h0, 1, 0);
        chk("mask_head1", 64'(out_data), 64'(r(16'h3003, 3'd0, 16'h0022)));
        step(0, 3'd0, 16'h0, 16'h0, 1, 0);
        chk("mask_empty", 64'(count), 64'd0);

        watch_mask = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            step(1, 3'(i), 16'h0100 + 16'(i), 16'h4000 + 16'(i), 0, 0);
            if (i == 3) chk("fill_ovf0", 64'(overflow), 64'd0);
        end
        chk("full_count", 64'(count), 64'd4);
        chk("full_ovf", 64'(overflow), 64'd1);
        chk("full_drop", 64'(drop_cnt), 64'd2);
        chk("full_head", 64'(out_data), 64'(r(16'h4000, 3'd0, 16'h0100)));

        step(1, 3'd6, 16'h0106, 16'h4006, 1, 0);
        chk("fpp_count", 64'(count), 64'd4);
        chk("fpp_drop", 64'(drop_cnt), 64'd2);
        chk("fpp_head", 64'(out_data), 64'(r(16'h4001, 3'd1, 16'h0101)));
        step(0, 3'd0, 16'h0, 16'h0, 1, 0);
        chk("drain_h2", 64'(out_data), 64'(r(16'h4002, 3'd2, 16'h0102)));
        step(0, 3'd0, 16'h0, 16'h0, 1, 0);
        chk("drain_h3", 64'(out_data), 64'(r(16'h4003, 3'd3, 16'h0103)));
        step(0, 3'd0, 16'h0, 16'h0, 1, 0);
        chk("drain_h6", 64'(out_data), 64'(r(16'h4006, 3'd6, 16'h0106)));
        chk("drain_c1", 64'(count), 64'd1);
        step(0, 3'd0, 16'h0, 16'h0, 1, 0);
        chk("drain_c0", 64'(count), 64'd0);
        chk("drain_ovf", 64'(overflow), 64'd1);

        step(1, 3'd5, 16'h0055, 16'h4100, 0, 0);
        step(1, 3'd4, 16'h0044, 16'h4101, 0, 1);
        chk("clr_count", 64'(count), 64'd0);
        chk("clr_valid", 64'(out_valid), 64'd0);
        chk("clr_ovf", 64'(overflow), 64'd0);
        chk("clr_drop", 64'(drop_cnt), 64'd0);
        chk("clr_data", 64'(out_data), 64'd0);

        step(1, 3'd2, 16'h0000, 16'h5000, 0, 0);
        step(1, 3'd2, 16'h1234, 16'h5001, 0, 0);
        step(1, 3'd2, 16'h1234, 16'h5002, 0, 0);
`ifdef TRACE_DEDUP_EN
        chk("dedup_count", 64'(count), 64'd1);
        chk("dedup_head", 64'(out_data), 64'(r(16'h5001, 3'd2, 16'h1234)));
`else
        chk("dedup_count", 64'(count), 64'd3);
        chk("dedup_head", 64'(out_data), 64'(r(16'h5000, 3'd2, 16'h0000)));
`endif

        step(0, 3'd0, 16'h0, 16'h0, 0, 1);
        for (int i = 0; i < 262; i++) step(1, 3'd7, 16'h0200 + 16'(i), 16'h6000, 0, 0);
        chk("sat_drop", 64'(drop_cnt), 64'd255);
        chk("sat_count", 64'(count), 64'd4);
        chk("sat_head", 64'(out_data), 64'(r(16'h6000, 3'd7, 16'h0200)));

        step(0, 3'd0, 16'h0, 16'h0, 0, 1);
        step(1, 3'd3, 16'h0001, 16'h7000, 0, 0);
        step(1, 3'd3, 16'h0002, 16'h7001, 0, 0);
        step(1, 3'd3, 16'h0003, 16'h7002, 0, 0);
        chk("pre_arst_count", 64'(count), 64'd3);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_ovf", 64'(overflow), 64'd0);
        chk("arst_drop", 64'(drop_cnt), 64'd0);
        chk("arst_data", 64'(out_data), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
